// File: rtl/fsm_xor_accum.sv
// fsm_xor_accum: NOR-gated XOR accumulator with a fixed-encoding FSM
// and a registered valid/ready result handshake (TMR test vehicle).
module fsm_xor_accum #(
   parameter int               WIDTH = 8,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] INIT  = '0,
   localparam int              CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] in2,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             busy,
   output logic [CW-1:0]    count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ACCUM = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   // State kept as raw bits so the illegal 2'b11 code is representable.
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_data;
   logic [CW-1:0]    r_count;
   logic             r_valid;

   logic [WIDTH-1:0] w_in_buf;
   logic [WIDTH-1:0] w_acc_next;

   assign w_in_buf   = ~in & ~in2;
   assign w_acc_next = r_acc ^ w_in_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= INIT;
         r_data  <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_ACCUM;
                  r_acc   <= INIT;
                  r_count <= '0;
               end
            end
            S_ACCUM: begin
               if (in_valid) begin
                  r_acc <= w_acc_next;
                  if (r_count == LAST) begin
                     r_state <= S_DONE;
                     r_data  <= w_acc_next;
                     r_valid <= 1'b1;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
                  r_count <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = r_data;
   assign out_valid = r_valid;
   assign count     = r_count;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fsm_xor_accum.sv
// tb_fsm_xor_accum: directed scoreboard bench for fsm_xor_accum,
// DEPTH=4 instance plus a DEPTH=1 / INIT=0xA5 instance.
module tb_fsm_xor_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start, in_valid, out_ready;
   logic [7:0] d_in, d_in2;
   logic [7:0] data_out;
   logic       out_valid, busy;
   logic [1:0] count;

   logic       start_b, in_valid_b, out_ready_b;
   logic [7:0] d_in_b, d_in2_b;
   logic [7:0] data_out_b;
   logic       out_valid_b, busy_b;
   logic [0:0] count_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];
   logic [7:0] m_acc;
   int         m_cnt;
   logic [7:0] hold;

   fsm_xor_accum #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in(d_in), .in2(d_in2), .out_ready(out_ready),
      .data_out(data_out), .out_valid(out_valid),
      .busy(busy), .count(count)
   );

   fsm_xor_accum #(.WIDTH(8), .DEPTH(1), .INIT(8'hA5)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
      .in(d_in_b), .in2(d_in2_b), .out_ready(out_ready_b),
      .data_out(data_out_b), .out_valid(out_valid_b),
      .busy(busy_b), .count(count_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_acc = 8'h00;
      m_cnt = 0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_cnt", 32'(count), 32'd0);
   endtask

   task automatic send_word(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      d_in     = a;
      d_in2    = b;
      m_acc    = m_acc ^ (~a & ~b);
      m_cnt++;
      if (m_cnt == 4) sb.push_back(m_acc);
      tick();
      in_valid = 1'b0;
      if (m_cnt < 4) chk("word_cnt", 32'(count), 32'(m_cnt));
      else chk("last_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic get_result();
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      chk("wait_valid", 32'(out_valid), 32'd1);
      if (sb.size() > 0) chk("data", 32'(data_out), 32'(sb.pop_front()));
      else chk("sb_empty", 32'(sb.size()), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_valid", 32'(out_valid), 32'd0);
      chk("hs_busy", 32'(busy), 32'd0);
      chk("hs_cnt", 32'(count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 0; in_valid = 0; out_ready = 0; d_in = 0; d_in2 = 0;
      start_b = 0; in_valid_b = 0; out_ready_b = 0; d_in_b = 0; d_in2_b = 0;
      m_acc = 0; m_cnt = 0;
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(count), 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: basic frame, expected 0x96
      start_frame();
      send_word(8'h0F, 8'h00);
      send_word(8'h33, 8'h00);
      send_word(8'h55, 8'h00);
      send_word(8'hFF, 8'h00);
      chk("t1_const", 32'(data_out), 32'h96);
      chk("t1_cnt3", 32'(count), 32'd3);
      get_result();

      // 2: masking, expected 0x0F
      tick();
      start_frame();
      send_word(8'h00, 8'hF0);
      send_word(8'hFF, 8'h00);
      send_word(8'hFF, 8'h00);
      send_word(8'hFF, 8'h00);
      chk("t2_const", 32'(data_out), 32'h0F);
      get_result();

      // 3: gaps between words, backpressure with start pulses in DONE
      start_frame();
      for (int w = 0; w < 4; w++) begin
         send_word(8'(1 << w), 8'h00);
         if (w < 3) begin
            for (int g = 0; g < 2; g++) begin
               d_in = 8'hAA;
               tick();
               chk("gap_cnt", 32'(count), 32'(m_cnt));
               chk("gap_busy", 32'(busy), 32'd1);
            end
         end
      end
      hold = data_out;
      chk("t3_const", 32'(data_out), 32'h0F);
      for (int k = 0; k < 3; k++) begin
         start    = 1'b1;
         in_valid = 1'b1;
         tick();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(data_out), 32'(hold));
         chk("bp_busy", 32'(busy), 32'd1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      get_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("one_result", 32'(out_valid), 32'd0);
      chk("retain", 32'(data_out), 32'(hold));

      // 4: reset mid-frame discards the frame
      start_frame();
      send_word(8'h12, 8'h00);
      send_word(8'h34, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_data", 32'(data_out), 32'd0);
      chk("mid_cnt", 32'(count), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start_frame();
      for (int w = 0; w < 4; w++) send_word(8'h00, 8'h00);
      chk("t4_const", 32'(data_out), 32'h00);
      get_result();

      // 5: illegal state recovery
      start_frame();
      send_word(8'h5A, 8'h00);
      force dut_a.r_state = 2'b11;
      #1;
      release dut_a.r_state;
      chk("ill_busy", 32'(busy), 32'd1);
      tick();
      chk("rec_busy", 32'(busy), 32'd0);
      chk("rec_valid", 32'(out_valid), 32'd0);
      chk("rec_cnt", 32'(count), 32'd0);
      chk("rec_data", 32'(data_out), 32'h00);
      start_frame();
      send_word(8'h12, 8'h0F);
      send_word(8'h34, 8'h0F);
      send_word(8'h56, 8'h0F);
      send_word(8'h78, 8'h0F);
      get_result();

      // 6: DEPTH=1 instance, INIT=0xA5
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_busy", 32'(busy_b), 32'd1);
      chk("b_cnt", 32'(count_b), 32'd0);
      in_valid_b = 1'b1;
      d_in_b     = 8'hFF;
      tick();
      in_valid_b = 1'b0;
      chk("b_valid", 32'(out_valid_b), 32'd1);
      chk("b_data", 32'(data_out_b), 32'hA5);
      chk("b_cnt0", 32'(count_b), 32'd0);
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
      chk("b_hs", 32'(out_valid_b), 32'd0);
      chk("b_idle", 32'(busy_b), 32'd0);
      chk("b_keep", 32'(data_out_b), 32'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_xor_accum.md
Name: fsm_xor_accum

Overview:
Parametrised successor of the single-bit NOR/XOR state test design. Gates a WIDTH-bit input word through a per-bit NOR mask (in_buf = ~in & ~in2), XOR-accumulates DEPTH valid words per frame in a registered state machine, and presents the result through a valid/ready output handshake. It is the sequential TMR test vehicle: the state register, accumulator and counter are the triplication targets. The fixed state encoding and illegal-state recovery let fault-injection benches check voting and self-correction.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 4, number of valid words accumulated per frame (>=1).
INIT, 0, WIDTH-bit accumulator seed loaded at frame start.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  frame start request, sampled in IDLE only.
in_valid  input  1  in/in2 carry a word this cycle.
in  input  WIDTH  data word.
in2  input  WIDTH  mask word; a bit set forces the gated bit to 0.
out_ready  input  1  consumer accepts data_out.
data_out  output  WIDTH  registered frame result.
out_valid  output  1  data_out holds an unaccepted result.
busy  output  1  high in any state other than IDLE.
count  output  max(1,$clog2(DEPTH))  words accumulated in the current frame.

Behaviour:
- Reset, asynchronous: state=IDLE, acc=INIT, count=0, data_out=0, out_valid=0, busy=0. Reset asserted mid-frame discards the frame; no partial result appears.
- in_buf = ~in & ~in2, bitwise. acc_next = acc ^ in_buf.
- State encoding is fixed: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10. Illegal 2'b11 moves to IDLE on the next edge, with count=0 and out_valid=0. data_out is not modified.
- IDLE: when start=1, go to ACCUM, load acc=INIT and count=0. in_valid in the same cycle as start is ignored. Otherwise stay in IDLE.
- ACCUM: each cycle with in_valid=1 sets acc<=acc_next and count<=count+1. Cycles with in_valid=0 hold all state. start is ignored.
- The DEPTH-th valid word (count==DEPTH-1 with in_valid=1) moves to DONE. On that same edge, data_out<=acc_next and out_valid<=1, so latency is 1 cycle from the last word to out_valid.
- DONE: out_valid=1 and data_out stays stable until out_ready=1.
  - The edge where out_valid&out_ready=1 goes to IDLE, clears out_valid, and resets count to 0.
  - out_ready may be held high continuously; that gives a single-cycle DONE.
  - in_valid and start are ignored in DONE.
- A start in the first IDLE cycle after the handshake opens a new frame. Back-to-back frames lose one cycle (the IDLE cycle).
- DEPTH=1: the first valid word goes directly to DONE. count stays 0.
- data_out retains the last result after the handshake, until reset.
- busy = (state != IDLE), decoded from the registered state.
- There is no combinational path from any input to any output.

Test Plan:
1. WIDTH=8, DEPTH=4, INIT=0, in2=0. Pulse start, then send in=0x0F,0x33,0x55,0xFF on consecutive cycles. in_buf is F0,CC,AA,00. Required: out_valid rises 1 cycle after the 4th word, with data_out=0x96 and count=3→0 after handshake.
2. Masking: word 1 in=0x00/in2=0xF0, then 3 words in=0xFF/in2=0x00. Required: data_out=0x0F.
3. Gaps and backpressure: insert 2 in_valid=0 cycles between words and hold out_ready=0 for 3 cycles after completion. Required: count holds during the gaps; out_valid and data_out stay stable; busy=1; start pulses in DONE are ignored. The release of out_ready yields exactly one accepted result, then IDLE.
4. Reset mid-frame: assert rst_n=0 after 2 words. Required: the same cycle shows out_valid=0, data_out=0, count=0 and busy=0. A following full frame of four 0x00 words (in_buf=FF) gives data_out=0x00.
5. Illegal state: force the state register to 2'b11 in ACCUM. Required: IDLE on the next edge, busy=0, out_valid=0. The next start/frame completes normally.
6. DEPTH=1, INIT=0xA5: start, then one word in=0xFF. Required: data_out=0xA5, with out_valid 1 cycle after the word.
